// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI memory slave: burst/response codes, engine states, WRAP length rule.
// Pure declarations; no timing or flow-control behaviour lives here.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; zero latency, no flow control.
// Illegal WRAP lengths fall back to INCR stepping (such bursts are already flagged as errors).
module axi_burst_addr
    import axi_slv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_win_mask;
    logic [ADDR_W-1:0] w_step;
    burst_e            w_burst;

    assign w_burst    = burst_e'(i_burst);
    assign w_incr     = ADDR_W'(1) << i_size;
    assign w_win_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
    assign w_step     = i_addr + w_incr;

    always_comb begin
        o_addr = w_step;
        if (w_burst == FIXED) begin
            o_addr = i_addr;
        end else if (w_burst == WRAP && wrap_len_ok(i_len)) begin
            o_addr = (i_addr & ~w_win_mask) | (w_step & w_win_mask);
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave with internal memory; one outstanding burst per direction, independent R/W engines.
// All outputs registered; AR->first R beat 1 cycle, 1 beat/cycle under rready, R held stable while stalled.
module axi_mem_slave
    import axi_slv_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int XW     = ADDR_W + 16;

    // Range check uses the extreme beat address in a widened space so bursts can't wrap past 0.
    function automatic resp_e chk_resp(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [XW-1:0] a;
        logic [XW-1:0] last;
        logic [XW-1:0] win;
        a    = XW'(addr);
        win  = (XW'(len) + XW'(1)) << size;
        last = a + (XW'(len) << size);
        if (burst == 2'(FIXED) || burst == 2'd3) begin
            last = a;
        end else if (burst == 2'(WRAP) && wrap_len_ok(len)) begin
            last = (a & ~(win - XW'(1))) + win - (XW'(1) << size);
        end
        if ((a >> LSB) >= XW'(MEM_WORDS) || (last >> LSB) >= XW'(MEM_WORDS)) begin
            return DECERR;
        end
        if (size > 3'(LSB) || burst == 2'd3 || (burst == 2'(WRAP) && !wrap_len_ok(len))) begin
            return SLVERR;
        end
        return OKAY;
    endfunction

    function automatic logic [MEM_AW-1:0] widx(input logic [ADDR_W-1:0] a);
        return MEM_AW'(a >> LSB);
    endfunction

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    wstate_e           r_wstate;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [ID_W-1:0]   r_bid;
    resp_e             r_bresp;
    logic [ID_W-1:0]   r_wid;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst;
    logic [7:0]        r_wcnt;
    resp_e             r_werr;
    logic              r_wproto;

    rstate_e           r_rstate;
    logic              r_arready;
    logic              r_rvalid;
    logic              r_rlast;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    resp_e             r_rresp;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rlen;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst;
    logic [7:0]        r_rcnt;

    logic [ADDR_W-1:0] w_wnext;
    logic [ADDR_W-1:0] w_rnext;
    logic              w_mem_we;
    resp_e             w_ar_err;

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_waddr (
        .i_addr  (r_waddr),
        .i_len   (r_wlen),
        .i_size  (r_wsize),
        .i_burst (r_wburst),
        .o_addr  (w_wnext)
    );

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_raddr (
        .i_addr  (r_raddr),
        .i_len   (r_rlen),
        .i_size  (r_rsize),
        .i_burst (r_rburst),
        .o_addr  (w_rnext)
    );

    assign w_mem_we = (r_wstate == W_DATA) && wvalid && r_wready && (r_werr == OKAY);
    assign w_ar_err = chk_resp(araddr, arlen, arsize, arburst);

    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    r_mem[widx(r_waddr)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= OKAY;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wsize   <= '0;
            r_wburst  <= '0;
            r_wcnt    <= '0;
            r_werr    <= OKAY;
            r_wproto  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (awvalid && r_awready) begin
                        r_wid     <= awid;
                        r_waddr   <= awaddr;
                        r_wlen    <= awlen;
                        r_wsize   <= awsize;
                        r_wburst  <= awburst;
                        r_werr    <= chk_resp(awaddr, awlen, awsize, awburst);
                        r_wcnt    <= '0;
                        r_wproto  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && r_wready) begin
                        r_waddr <= w_wnext;
                        r_wcnt  <= r_wcnt + 8'd1;
                        // Beat count, not wlast, terminates the burst.
                        if (r_wcnt == r_wlen) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_wid;
                            if (r_werr != OKAY) begin
                                r_bresp <= r_werr;
                            end else if (r_wproto || !wlast) begin
                                r_bresp <= SLVERR;
                            end else begin
                                r_bresp <= OKAY;
                            end
                            r_wstate <= W_RESP;
                        end else if (wlast) begin
                            r_wproto <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= OKAY;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (arvalid && r_arready) begin
                        r_arready <= 1'b0;
                        r_rid     <= arid;
                        r_raddr   <= araddr;
                        r_rlen    <= arlen;
                        r_rsize   <= arsize;
                        r_rburst  <= arburst;
                        r_rcnt    <= '0;
                        r_rresp   <= w_ar_err;
                        r_rdata   <= (w_ar_err == OKAY) ? r_mem[widx(araddr)] : '0;
                        r_rlast   <= (arlen == 8'd0);
                        r_rvalid  <= 1'b1;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            // Next beat is fetched at the handshake so stalls never disturb R outputs.
                            r_raddr <= w_rnext;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rdata <= (r_rresp == OKAY) ? r_mem[widx(w_rnext)] : '0;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised bench for axi_mem_slave against a byte-level memory model and burst-address arithmetic.
module tb_axi_mem_slave;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int MEM_WORDS = 1024;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [ID_W-1:0]   awid = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [7:0]        awlen = '0;
    logic [2:0]        awsize = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wlast = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [ID_W-1:0]   arid = '0;
    logic [ADDR_W-1:0] araddr = '0;
    logic [7:0]        arlen = '0;
    logic [2:0]        arsize = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b0;

    always #5 aclk = ~aclk;

    axi_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_WORDS(MEM_WORDS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [MEM_WORDS];

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic        wr_last [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    bit          wr_aw_ok, wr_b_ok, wr_ret_ok;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id [16];
    bit          rd_first_ok, rd_ret_ok;
    int          rd_stall_bad;
    int          rd_mode;

    // Beat address from first principles: offset within an aligned wrap window, modulo its size.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                              input int burst, input int i);
        longint step, wb, base;
        step = longint'(1) << size;
        if (burst == 0) return a;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            wb   = (len + 1) * step;
            base = (longint'(a) / wb) * wb;
            return 32'(base + ((longint'(a) - base) + i * step) % wb);
        end
        return 32'(longint'(a) + i * step);
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a, input int len, input int size,
                                              input int burst);
        for (int i = 0; i <= len; i++) begin
            if ((beat_addr(a, len, size, burst, i) / 4) >= MEM_WORDS) return 2'd3;
        end
        if (size > 2 || burst == 3) return 2'd2;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_write(input logic [31:0] a, input int len, input int size, input int burst);
        int w;
        if (model_resp(a, len, size, burst) != 2'd0) return;
        for (int i = 0; i <= len; i++) begin
            w = int'(beat_addr(a, len, size, burst, i) / 4);
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[i][b]) ref_mem[w][8*b +: 8] = wr_data[i][8*b +: 8];
            end
        end
    endtask

    task automatic prep_wr(input int len, input bit rnd_strb);
        for (int i = 0; i < 16; i++) begin
            wr_data[i] = $urandom;
            wr_strb[i] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
            wr_last[i] = (i == len);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst);
        int n;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL aw_timeout: awready stayed %b", awready); end
        @(negedge aclk);
        awvalid = 1'b0;
        wr_aw_ok = (awready === 1'b0 && wready === 1'b1);
        for (int i = 0; i <= len; i++) begin
            wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = wr_last[i]; wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
            if (n >= 200) begin checks++; errors++; $display("FAIL w_timeout: beat %0d wready %b", i, wready); end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        wr_b_ok = (bvalid === 1'b1);
        bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL b_timeout: bvalid %b", bvalid); end
        b_resp = bresp; b_id = bid;
        @(negedge aclk);
        bready = 1'b0;
        wr_ret_ok = (awready === 1'b1 && bvalid === 1'b0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst);
        int n, beat;
        bit rr, s_v, s_l;
        logic [31:0] s_d;
        logic [1:0] s_r;
        logic [3:0] s_i;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL ar_timeout: arready %b", arready); end
        @(negedge aclk);
        arvalid = 1'b0;
        rd_first_ok = (rvalid === 1'b1 && arready === 1'b0);
        beat = 0; n = 0; rd_stall_bad = 0;
        while (beat <= len && n < 2000) begin
            rr = (rd_mode == 0) ? 1'b1 : (rd_mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
            rready = rr;
            s_v = rvalid; s_d = rdata; s_r = rresp; s_l = rlast; s_i = rid;
            @(negedge aclk);
            n++;
            if (s_v !== 1'b1) begin
                rd_stall_bad++;
            end else if (rr) begin
                rd_data[beat] = s_d; rd_resp[beat] = s_r; rd_last[beat] = s_l; rd_id[beat] = s_i;
                beat++;
            end else if (rvalid !== 1'b1 || rdata !== s_d || rresp !== s_r || rlast !== s_l || rid !== s_i) begin
                rd_stall_bad++;
            end
        end
        rready = 1'b0;
        if (n >= 2000) begin checks++; errors++; $display("FAIL r_timeout: got %0d beats", beat); end
        rd_ret_ok = (arready === 1'b1 && rvalid === 1'b0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge aclk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, bid, rid, bresp, rresp, rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got aw%b ar%b w%b b%b r%b l%b rdata %h", awready, arready,
                     wready, bvalid, rvalid, rlast, rdata);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0 || arready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: aw %b ar %b expected 0 0", awready, arready);
        end
        @(negedge aclk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge: aw %b ar %b expected 1 1", awready, arready);
        end
    endtask

    task automatic test_fill;
        for (int k = 0; k < 8; k++) begin
            prep_wr(15, 1'b0);
            do_write(4'(k), 32'(k * 64), 15, 2, 1);
            model_write(32'(k * 64), 15, 2, 1);
            checks++;
            if (b_resp !== 2'd0) begin errors++; $display("FAIL fill_bresp: got %0d expected 0", b_resp); end
        end
    endtask

    task automatic test_incr;
        logic [3:0] id;
        id = 4'($urandom_range(0, 15));
        prep_wr(3, 1'b0);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + 32'(i);
        do_write(id, 32'h10, 3, 2, 1);
        model_write(32'h10, 3, 2, 1);
        checks++;
        if (b_resp !== 2'd0 || b_id !== id) begin
            errors++; $display("FAIL incr_b: resp %0d id %0d expected 0 %0d", b_resp, b_id, id);
        end
        checks++;
        if (!wr_aw_ok || !wr_b_ok || !wr_ret_ok) begin
            errors++; $display("FAIL write_timing: aw %b b %b ret %b expected 1 1 1", wr_aw_ok, wr_b_ok, wr_ret_ok);
        end
        rd_mode = 0;
        do_read(~id, 32'h10, 3, 2, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'hA0 + 32'(i) || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'd0 || rd_id[i] !== ~id) begin
                errors++;
                $display("FAIL incr_read beat %0d: data %h last %b resp %0d id %0d expected %h %b 0 %0d",
                         i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], 32'hA0 + 32'(i), (i == 3), ~id);
            end
        end
        checks++;
        if (!rd_first_ok || !rd_ret_ok || rd_stall_bad != 0) begin
            errors++; $display("FAIL read_timing: first %b ret %b gaps %0d expected 1 1 0", rd_first_ok, rd_ret_ok, rd_stall_bad);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] wa [4];
        wa[0] = 32'h38; wa[1] = 32'h3C; wa[2] = 32'h30; wa[3] = 32'h34;
        rd_mode = 0;
        do_read(4'd5, 32'h38, 3, 2, 2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== ref_mem[wa[i] / 4] || rd_resp[i] !== 2'd0) begin
                errors++; $display("FAIL wrap_beat %0d: data %h resp %0d expected %h 0", i, rd_data[i], rd_resp[i], ref_mem[wa[i] / 4]);
            end
        end
        do_read(4'd6, 32'h38, 2, 2, 2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'd2 || rd_last[i] !== (i == 2)) begin
                errors++; $display("FAIL wrap_badlen %0d: data %h resp %0d last %b expected 0 2 %b", i, rd_data[i], rd_resp[i], rd_last[i], (i == 2));
            end
        end
    endtask

    task automatic test_partial;
        prep_wr(0, 1'b0);
        wr_data[0] = 32'h11223344;
        do_write(4'd1, 32'h80, 0, 2, 1);
        model_write(32'h80, 0, 2, 1);
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'h3;
        do_write(4'd2, 32'h80, 0, 2, 1);
        model_write(32'h80, 0, 2, 1);
        rd_mode = 0;
        do_read(4'd3, 32'h80, 0, 2, 1);
        checks++;
        if (rd_data[0] !== 32'h1122BEEF || rd_last[0] !== 1'b1) begin
            errors++; $display("FAIL partial_strobe: data %h last %b expected 1122beef 1", rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_out_of_range;
        prep_wr(0, 1'b0);
        wr_data[0] = 32'h5A5A0FF0;
        do_write(4'd7, 32'hFFC, 0, 2, 1);
        model_write(32'hFFC, 0, 2, 1);
        prep_wr(0, 1'b0);
        do_write(4'd8, 32'(MEM_WORDS * 4), 0, 2, 1);
        checks++;
        if (b_resp !== 2'd3) begin errors++; $display("FAIL oor_bresp: got %0d expected 3", b_resp); end
        prep_wr(1, 1'b0);
        do_write(4'd9, 32'hFFC, 1, 2, 1);
        checks++;
        if (b_resp !== 2'd3) begin errors++; $display("FAIL cross_bresp: got %0d expected 3", b_resp); end
        rd_mode = 0;
        do_read(4'd1, 32'hFFC, 0, 2, 1);
        checks++;
        if (rd_data[0] !== 32'h5A5A0FF0 || rd_resp[0] !== 2'd0) begin
            errors++; $display("FAIL last_word_kept: data %h resp %0d expected 5a5a0ff0 0", rd_data[0], rd_resp[0]);
        end
        do_read(4'd2, 32'h0, 0, 2, 1);
        checks++;
        if (rd_data[0] !== ref_mem[0]) begin
            errors++; $display("FAIL word0_kept: data %h expected %h", rd_data[0], ref_mem[0]);
        end
        do_read(4'd3, 32'(MEM_WORDS * 4), 0, 2, 1);
        checks++;
        if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'd3 || rd_last[0] !== 1'b1) begin
            errors++; $display("FAIL oor_read: data %h resp %0d last %b expected 0 3 1", rd_data[0], rd_resp[0], rd_last[0]);
        end
    endtask

    task automatic test_wlast_errors;
        prep_wr(3, 1'b0);
        wr_last[1] = 1'b1; wr_last[3] = 1'b1;
        do_write(4'd4, 32'h800, 3, 2, 1);
        checks++;
        if (b_resp !== 2'd2 || !wr_b_ok) begin
            errors++; $display("FAIL early_wlast: resp %0d b_after_4 %b expected 2 1", b_resp, wr_b_ok);
        end
        prep_wr(1, 1'b0);
        wr_last[1] = 1'b0;
        do_write(4'd5, 32'h840, 1, 2, 1);
        checks++;
        if (b_resp !== 2'd2 || !wr_b_ok) begin
            errors++; $display("FAIL missing_wlast: resp %0d b_after_2 %b expected 2 1", b_resp, wr_b_ok);
        end
    endtask

    task automatic test_backpressure;
        for (int m = 1; m <= 2; m++) begin
            rd_mode = m;
            do_read(4'(m), 32'h40, 7, 2, 1);
            checks++;
            if (rd_stall_bad != 0 || !rd_ret_ok) begin
                errors++; $display("FAIL rready_stall mode %0d: unstable %0d ret %b expected 0 1", m, rd_stall_bad, rd_ret_ok);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rd_data[i] !== ref_mem[16 + i] || rd_last[i] !== (i == 7)) begin
                    errors++; $display("FAIL stall_data %0d: data %h last %b expected %h %b", i, rd_data[i], rd_last[i], ref_mem[16 + i], (i == 7));
                end
            end
        end
    endtask

    task automatic test_concurrent;
        logic [31:0] exp_rd [8];
        for (int i = 0; i < 8; i++) exp_rd[i] = ref_mem[i];
        prep_wr(7, 1'b0);
        rd_mode = 0;
        fork
            do_write(4'hA, 32'h600, 7, 2, 1);
            do_read(4'hB, 32'h0, 7, 2, 1);
        join
        model_write(32'h600, 7, 2, 1);
        checks++;
        if (b_resp !== 2'd0 || b_id !== 4'hA) begin
            errors++; $display("FAIL conc_bresp: resp %0d id %0d expected 0 10", b_resp, b_id);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data[i] !== exp_rd[i] || rd_resp[i] !== 2'd0 || rd_id[i] !== 4'hB) begin
                errors++; $display("FAIL conc_read %0d: data %h resp %0d expected %h 0", i, rd_data[i], rd_resp[i], exp_rd[i]);
            end
        end
        do_read(4'hC, 32'h600, 7, 2, 1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data[i] !== ref_mem[384 + i]) begin
                errors++; $display("FAIL conc_write %0d: data %h expected %h", i, rd_data[i], ref_mem[384 + i]);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        int n;
        @(negedge aclk);
        arid = 4'd9; araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        rready = 1'b0;
        n = 0;
        while (arready !== 1'b1 && n < 200) begin @(negedge aclk); n++; end
        if (n >= 200) begin checks++; errors++; $display("FAIL mid_ar_timeout: arready %b", arready); end
        @(negedge aclk);
        arvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid: got %b expected 1", rvalid); end
        aresetn = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0 || awready !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset: rvalid %b arready %b awready %b rdata %h expected 0 0 0 0", rvalid, arready, awready, rdata);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b0) begin errors++; $display("FAIL mid_release: arready %b expected 0", arready); end
        @(negedge aclk);
        checks++;
        if (arready !== 1'b1 || awready !== 1'b1) begin
            errors++; $display("FAIL mid_ready: arready %b awready %b expected 1 1", arready, awready);
        end
        rd_mode = 0;
        do_read(4'd1, 32'h0, 3, 2, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== ref_mem[i]) begin
                errors++; $display("FAIL mem_after_reset %0d: data %h expected %h", i, rd_data[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_random;
        int burst, size, len, step, r, w;
        logic [31:0] addr, exp_d;
        logic [1:0] exp_r;
        logic [3:0] id;
        for (int it = 0; it < 24; it++) begin
            r = $urandom_range(0, 9);
            burst = (r < 3) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            size = $urandom_range(0, 2);
            step = 1 << size;
            r = $urandom_range(0, 2);
            len = (burst == 2) ? ((r == 0) ? 1 : (r == 1) ? 3 : 7) : $urandom_range(0, 7);
            if (burst == 1) addr = 32'($urandom_range(0, (512 / step) - (len + 1)) * step);
            else addr = 32'($urandom_range(0, (512 / step) - 1) * step);
            id = 4'($urandom_range(0, 15));
            exp_r = model_resp(addr, len, size, burst);
            prep_wr(len, 1'b1);
            do_write(id, addr, len, size, burst);
            model_write(addr, len, size, burst);
            checks++;
            if (b_resp !== exp_r || b_id !== id) begin
                errors++; $display("FAIL rand_b it %0d: resp %0d id %0d expected %0d %0d", it, b_resp, b_id, exp_r, id);
            end
            rd_mode = 2;
            do_read(~id, addr, len, size, burst);
            for (int i = 0; i <= len; i++) begin
                w = int'(beat_addr(addr, len, size, burst, i) / 4);
                exp_d = (exp_r == 2'd0) ? ref_mem[w] : 32'h0;
                checks++;
                if (rd_data[i] !== exp_d || rd_resp[i] !== exp_r || rd_last[i] !== (i == len) || rd_id[i] !== ~id) begin
                    errors++;
                    $display("FAIL rand_r it %0d beat %0d: data %h resp %0d last %b expected %h %0d %b",
                             it, i, rd_data[i], rd_resp[i], rd_last[i], exp_d, exp_r, (i == len));
                end
            end
            checks++;
            if (rd_stall_bad != 0) begin errors++; $display("FAIL rand_stall it %0d: unstable %0d expected 0", it, rd_stall_bad); end
        end
    endtask

    initial begin
        rd_mode = 0;
        test_reset;
        test_fill;
        test_incr;
        test_wrap;
        test_partial;
        test_out_of_range;
        test_wlast_errors;
        test_backpressure;
        test_concurrent;
        test_reset_mid_read;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
